// File: rtl/axibram_rd_mux_if.sv
`default_nettype none
// ============================================================================
// axibram_rd_mux_if : BRAM-style read bus between AXI read controller and mux
// Rev 1.0
// ============================================================================
interface axibram_rd_mux_if #(
  parameter int ADDRESS_BITS = 10
);
  logic [ADDRESS_BITS-1:0] pre_araddr;
  logic                    start_burst;
  logic                    dev_ready;
  logic [ADDRESS_BITS-1:0] bram_raddr;
  logic                    bram_ren;
  logic                    bram_regen;
  logic [31:0]             bram_rdata;

  modport master (
    output pre_araddr,
    output start_burst,
    output bram_raddr,
    output bram_ren,
    output bram_regen,
    input  dev_ready,
    input  bram_rdata
  );

  modport slave (
    input  pre_araddr,
    input  start_burst,
    input  bram_raddr,
    input  bram_ren,
    input  bram_regen,
    output dev_ready,
    output bram_rdata
  );
endinterface
`default_nettype wire

// File: rtl/axibram_rd_mux.sv
`default_nettype none
// ============================================================================
// axibram_rd_mux : four-region read mux (RAM / status / FIFO / zero) behind a
//                  two-stage registered BRAM-style read port
// Rev 1.0
// ============================================================================
module axibram_rd_mux #(
  parameter int ADDRESS_BITS    = 10,
  parameter int FIFO_DEPTH_LOG2 = 4
) (
  input  logic                       aclk,
  input  logic                       rst,
  axibram_rd_mux_if.slave            rd,
  input  logic                       ram_we,
  input  logic [ADDRESS_BITS-3:0]    ram_waddr,
  input  logic [31:0]                ram_wdata,
  input  logic [255:0]               status_in,
  input  logic                       fifo_we,
  input  logic [31:0]                fifo_wdata,
  output logic                       fifo_full,
  output logic [FIFO_DEPTH_LOG2:0]   fifo_count,
  input  logic                       clr_err,
  output logic                       underflow,
  output logic                       overflow
);

  localparam int RAM_AW     = ADDRESS_BITS - 2;
  localparam int RAM_DEPTH  = 2 ** RAM_AW;
  localparam int FIFO_DEPTH = 2 ** FIFO_DEPTH_LOG2;
  localparam logic [FIFO_DEPTH_LOG2:0] COUNT_FULL = (FIFO_DEPTH_LOG2 + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    REG_RAM    = 2'd0,
    REG_STATUS = 2'd1,
    REG_FIFO   = 2'd2,
    REG_ZERO   = 2'd3
  } region_e;

  region_e                    sel_q, sel_d;
  logic [31:0]                s1_q, s1_d;
  logic [31:0]                bram_rdata_q, bram_rdata_d;
  logic [FIFO_DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_DEPTH_LOG2:0]   fifo_count_q, fifo_count_d;
  logic                       underflow_q, underflow_d;
  logic                       overflow_q, overflow_d;

  logic [31:0] ram_mem  [RAM_DEPTH];
  logic [31:0] fifo_mem [FIFO_DEPTH];

  logic              fifo_empty;
  logic              full_now;
  logic              pop_req;
  logic              pop_ok;
  logic              push_ok;
  logic [RAM_AW-1:0] ram_raddr;
  logic [2:0]        status_idx;

  assign ram_raddr  = rd.bram_raddr[RAM_AW-1:0];
  assign status_idx = rd.bram_raddr[2:0];

  assign fifo_empty = (fifo_count_q == '0);
  assign full_now   = (fifo_count_q == COUNT_FULL);
  assign pop_req    = rd.bram_ren && (sel_q == REG_FIFO);
  assign pop_ok     = pop_req && !fifo_empty;
  // A pop in the same cycle frees a slot, so a push into a full FIFO is taken.
  assign push_ok    = fifo_we && (!full_now || pop_ok);

  // Region select and stage-1 source; ren uses the select from before this cycle.
  always_comb begin
    sel_d = sel_q;
    s1_d  = s1_q;
    if (rd.start_burst) begin
      sel_d = region_e'(rd.pre_araddr[ADDRESS_BITS-1 -: 2]);
    end
    if (rd.bram_ren) begin
      case (sel_q)
        REG_RAM:    s1_d = ram_mem[ram_raddr];
        REG_STATUS: s1_d = status_in[{status_idx, 5'd0} +: 32];
        REG_FIFO:   s1_d = fifo_empty ? 32'd0 : fifo_mem[rd_ptr_q];
        default:    s1_d = 32'd0;
      endcase
    end
  end

  always_comb begin
    bram_rdata_d = bram_rdata_q;
    if (rd.bram_regen) begin
      bram_rdata_d = s1_q;
    end
  end

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    fifo_count_d = fifo_count_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push_ok, pop_ok})
      2'b10:   fifo_count_d = fifo_count_q + 1'b1;
      2'b01:   fifo_count_d = fifo_count_q - 1'b1;
      default: fifo_count_d = fifo_count_q;
    endcase
  end

  // New errors take priority over a clear in the same cycle.
  always_comb begin
    underflow_d = underflow_q && !clr_err;
    overflow_d  = overflow_q && !clr_err;
    if (pop_req && fifo_empty) begin
      underflow_d = 1'b1;
    end
    if (fifo_we && full_now && !pop_ok) begin
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge aclk or posedge rst) begin
    if (rst) begin
      sel_q        <= REG_RAM;
      s1_q         <= 32'd0;
      bram_rdata_q <= 32'd0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fifo_count_q <= '0;
      underflow_q  <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      sel_q        <= sel_d;
      s1_q         <= s1_d;
      bram_rdata_q <= bram_rdata_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fifo_count_q <= fifo_count_d;
      underflow_q  <= underflow_d;
      overflow_q   <= overflow_d;
    end
  end

  // Storage arrays carry no reset so they can map onto block/distributed RAM.
  always_ff @(posedge aclk) begin
    if (ram_we) begin
      ram_mem[ram_waddr] <= ram_wdata;
    end
  end

  always_ff @(posedge aclk) begin
    if (push_ok) begin
      fifo_mem[wr_ptr_q] <= fifo_wdata;
    end
  end

  // dev_ready feeds start_burst upstream, so it must come from registers only.
  assign rd.dev_ready  = (sel_q != REG_FIFO) || !fifo_empty;
  assign rd.bram_rdata = bram_rdata_q;
  assign fifo_full     = full_now;
  assign fifo_count    = fifo_count_q;
  assign underflow     = underflow_q;
  assign overflow      = overflow_q;

endmodule
`default_nettype wire
